// File: rtl/rom_rdr_pkg.sv
// Shared types and constants for the ROM stream reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rom_rdr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Reads in flight: one in the rom_en register, one in the ROM output register.
    localparam int MAX_INFLIGHT = 2;
    localparam int INFLIGHT_W   = $clog2(MAX_INFLIGHT + 1);

endpackage

// File: rtl/rom_rdr_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible combinationally on rd_dat.
// Latency: a word written at edge N is readable after edge N.
// Backpressure: writes when full are dropped unless a read happens in the same cycle.
module rom_rdr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic [CNT_W-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_rd  = rd_en && (cnt != '0);
    assign do_wr  = wr_en && ((cnt != CNT_W'(DEPTH)) || do_rd);
    assign rd_dat = mem[rd_ptr];

    // Pointers and occupancy; these alone define which slots hold live data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: slots are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/rom_stream_reader.sv
// Burst sequencer for a registered-read ROM, presenting the words as a valid/ready stream (optional checksum: ROM_RDR_CHECKSUM_EN).
// Latency: start at edge E0 -> rom_en after E0 -> word in output FIFO and m_valid after E2; 1 word/cycle sustained.
// Backpressure: reads issue only while FIFO count plus reads in flight is below FIFO_DEPTH, so no word is ever dropped.
module rom_stream_reader
    import rom_rdr_pkg::*;
#(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
`ifdef ROM_RDR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int              CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    state_t                  state;
    state_t                  state_nxt;
    logic                    done_nxt;
    logic                    issue;
    logic                    issue_last;
    logic                    accept;
    logic [LEN_W-1:0]        len_eff;
    logic [LEN_W-1:0]        remaining;
    logic [ADDR_W-1:0]       next_addr;
    logic                    en_last;
    logic                    rd_vld;
    logic                    rd_last;
    logic [INFLIGHT_W-1:0]   inflight;
    logic                    room;
    logic                    pop;
    logic                    drained;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [DATA_W:0]         fifo_head;

    assign len_eff  = (len > MAX_LEN) ? MAX_LEN : len;
    assign inflight = INFLIGHT_W'(rom_en) + INFLIGHT_W'(rd_vld);
    assign room     = (int'(fifo_cnt) + int'(inflight)) < FIFO_DEPTH;
    assign m_valid  = (fifo_cnt != '0);
    assign pop      = m_valid && m_ready;
    assign m_data   = m_valid ? fifo_head[DATA_W-1:0] : '0;
    assign m_last   = m_valid && fifo_head[DATA_W];
    assign busy     = (state != IDLE);
    assign drained  = (inflight == '0) &&
                      ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));

    // State and done pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    // Next state, read issue decision and completion detection.
    always_comb begin
        state_nxt  = state;
        done_nxt   = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (len_eff == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        issue      = 1'b1;
                        issue_last = (len_eff == LEN_W'(1));
                        state_nxt  = issue_last ? DRAIN : RUN;
                    end
                end
            end
            RUN: begin
                if ((remaining != '0) && room) begin
                    issue      = 1'b1;
                    issue_last = (remaining == LEN_W'(1));
                    if (issue_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read pipe: rom_en/addr out, then a valid+last shadow of the ROM register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_en    <= 1'b0;
            rom_addr  <= '0;
            next_addr <= '0;
            remaining <= '0;
            en_last   <= 1'b0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rom_en  <= issue;
            en_last <= issue_last;
            rd_vld  <= rom_en;
            rd_last <= en_last;
            if (issue) begin
                if (state == IDLE) begin
                    rom_addr  <= start_addr;
                    next_addr <= start_addr + ADDR_W'(1);
                    remaining <= len_eff - LEN_W'(1);
                end else begin
                    rom_addr  <= next_addr;
                    next_addr <= next_addr + ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
            end
        end
    end

    rom_rdr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W + 1),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (rd_vld),
        .wr_dat ({rd_last, rom_data}),
        .rd_en  (pop),
        .rd_dat (fifo_head),
        .cnt    (fifo_cnt)
    );

`ifdef ROM_RDR_CHECKSUM_EN
    // Running XOR of words handed downstream; cleared when a new command is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum ^ fifo_head[DATA_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_rom_stream_reader.sv
// Directed bench for rom_stream_reader with a registered-read 8x16 ROM model.
// Latency: checks start-to-rom_en, start-to-m_valid and last-word-to-done timing.
// Backpressure: exercises a stalled then toggling m_ready and bounds outstanding reads.
module tb_rom_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  start_addr = '0;
    logic [3:0]  len = '0;
    logic        m_ready = 1'b0;
    logic        busy, done, rom_en, m_valid, m_last;
    logic [2:0]  rom_addr;
    logic [15:0] rom_data, m_data;
`ifdef ROM_RDR_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [15:0] rom [8] = '{16'haaaa, 16'habcd, 16'h9999, 16'h2121,
                             16'h8585, 16'h4258, 16'h7b4e, 16'h9a2b};
    logic [15:0] rom_q = '0;
    logic        rom_v = 1'b0;

    int total = 0;
    int bad = 0;
    int cyc_cnt = 0;
    int issued = 0;
    int popped = 0;
    int occ_max = 0;
    int en_cycs[$];
    int val_cycs[$];
    int busy_cycs[$];
    int done_cycs[$];
    int xfer_cycs[$];
    logic [16:0] xq[$];
    int s_cyc = 0;
    int s_xb = 0;

    always #5 clk = ~clk;

    rom_stream_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef ROM_RDR_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // ROM: registered read, garbage on the bus when no read returns.
    always @(posedge clk) begin
        rom_v <= rom_en;
        if (rom_en) rom_q <= rom[rom_addr];
    end
    assign rom_data = rom_v ? rom_q : 16'hdead;

    // Observe on the falling edge, when all DUT outputs are settled.
    always @(negedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (!rst) begin
            if (rom_en) begin
                en_cycs.push_back(cyc_cnt);
                issued = issued + 1;
            end
            if (issued - popped > occ_max) occ_max = issued - popped;
            if (m_valid) val_cycs.push_back(cyc_cnt);
            if (busy) busy_cycs.push_back(cyc_cnt);
            if (done) done_cycs.push_back(cyc_cnt);
            if (m_valid && m_ready) begin
                xq.push_back({m_last, m_data});
                xfer_cycs.push_back(cyc_cnt);
                popped = popped + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic int first_after(input int q[$], input int c);
        foreach (q[i]) if (q[i] > c) return q[i];
        return -1;
    endfunction

    function automatic int count_after(input int q[$], input int c);
        int n = 0;
        foreach (q[i]) if (q[i] > c) n++;
        return n;
    endfunction

    task automatic start_cmd(input logic [2:0] a, input logic [3:0] l, input int mode);
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = a;
        len        = l;
        m_ready    = (mode == 0);
        s_cyc      = cyc_cnt;
        s_xb       = xq.size();
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int mode, input bit poke);
        for (int k = 0; k < 400; k++) begin
            if (mode == 1) m_ready = (k >= 10) && (k % 2 == 0);
            if (poke && k == 3) begin
                start = 1'b1; start_addr = 3'd5; len = 4'd2;
            end
            if (poke && k == 4) start = 1'b0;
            if (count_after(done_cycs, s_cyc) != 0) break;
            @(posedge clk); #1;
        end
        check({tag, "_done_seen"}, (count_after(done_cycs, s_cyc) != 0) ? 1 : 0, 1);
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_words(input string tag, input int a, input int l);
        check({tag, "_count"}, xq.size() - s_xb, l);
        for (int i = 0; i < l; i++) begin
            logic [16:0] exp;
            exp = {(i == l - 1), rom[(a + i) % 8]};
            if (s_xb + i < xq.size())
                check($sformatf("%s_w%0d", tag, i), 32'(xq[s_xb + i]), 32'(exp));
        end
    endtask

    initial begin
        int lx;
        int d0;

        // Reset values
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
`ifdef ROM_RDR_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        #10 rst = 1'b0;

        // Full burst, ready held high: latency and 1 word/cycle
        start_cmd(3'd0, 4'd8, 0);
        wait_done("full", 0, 0);
        check_words("full", 0, 8);
        check("full_en_lat", first_after(en_cycs, s_cyc) - s_cyc, 2);
        check("full_valid_lat", first_after(val_cycs, s_cyc) - s_cyc, 4);
        lx = xfer_cycs[$];
        check("full_span", lx - first_after(xfer_cycs, s_cyc), 7);
        check("full_done_lat", first_after(done_cycs, s_cyc) - lx, 1);
        check("full_done_cnt", count_after(done_cycs, s_cyc), 1);

        // Address wrap 6,7,0,1
        start_cmd(3'd6, 4'd4, 0);
        wait_done("wrap", 0, 0);
        check_words("wrap", 6, 4);
`ifdef ROM_RDR_CHECKSUM_EN
        check("wrap_checksum", checksum, 32'he002);
`endif

        // Zero-length command
        start_cmd(3'd3, 4'd0, 0);
        wait_done("zero", 0, 0);
        check("zero_done_lat", first_after(done_cycs, s_cyc) - s_cyc, 2);
        check("zero_done_cnt", count_after(done_cycs, s_cyc), 1);
        check("zero_valid", count_after(val_cycs, s_cyc), 0);
        check("zero_busy", count_after(busy_cycs, s_cyc), 0);
        check_words("zero", 3, 0);

        // Start while busy is ignored
        start_cmd(3'd1, 4'd6, 0);
        wait_done("poke", 0, 1);
        check_words("poke", 1, 6);
        check("poke_done_cnt", count_after(done_cycs, s_cyc), 1);

        // Backpressure: stalled 10 cycles then toggling
        start_cmd(3'd0, 4'd8, 1);
        wait_done("bp", 1, 0);
        check_words("bp", 0, 8);
        check("bp_max_outstanding", occ_max, 4);

        // Reset mid-burst aborts without done
        start_cmd(3'd0, 4'd8, 0);
        repeat (2) @(posedge clk);
        #3;
        d0 = done_cycs.size();
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_rom_en", rom_en, 0);
        check("abort_rom_addr", rom_addr, 0);
        check("abort_m_valid", m_valid, 0);
        check("abort_m_last", m_last, 0);
        check("abort_m_data", m_data, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", done_cycs.size() - d0, 0);
        start_cmd(3'd2, 4'd1, 0);
        wait_done("single", 0, 0);
        check_words("single", 2, 1);
        check("single_done_cnt", count_after(done_cycs, s_cyc), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
